// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory fetch port, redirect input and IF/ID output handshake.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          fetch_enable;
    logic [63:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          out_valid;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic [CW-1:0] count;

    modport slave (
        input  fetch_enable, imem_data, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_pc, out_instr, count
    );

    modport master (
        output fetch_enable, imem_data, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between a combinational instruction memory and the IF/ID register.
// Define FETCH_QUEUE_BYPASS_EN for a 0-cycle path from memory to output when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    fetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   pc_mem_q    [DEPTH];
    logic [63:0]   pc_mem_d    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];

    logic head_avail;
    logic rd_en;
    logic wr_en;
    logic fetch_go;

    assign head_avail    = (count_q != '0);
    assign bus.imem_addr = fetch_pc_q;
    assign bus.count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_act;
    // Gated by reset_n so the output stays invalid while reset is held.
    assign bypass_act = reset_n & ~head_avail & bus.fetch_enable & ~bus.redirect_valid;
`endif

    always_comb begin
        rd_en    = head_avail & bus.out_ready & ~bus.redirect_valid;
        fetch_go = bus.fetch_enable & ~bus.redirect_valid & ((count_q != FULL) | rd_en);
`ifdef FETCH_QUEUE_BYPASS_EN
        // A bypassed instruction that is accepted immediately never occupies a slot.
        wr_en    = fetch_go & ~(bypass_act & bus.out_ready);
`else
        wr_en    = fetch_go;
`endif
    end

    always_comb begin
        bus.out_valid = head_avail;
        bus.out_pc    = head_avail ? pc_mem_q[head_q]    : '0;
        bus.out_instr = head_avail ? instr_mem_q[head_q] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass_act) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = fetch_pc_q;
            bus.out_instr = bus.imem_data;
        end
`endif
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (fetch_go) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            // DEPTH is a power of two, so pointer overflow is the wrap to 0.
            if (wr_en) begin
                pc_mem_d[tail_q]    = fetch_pc_q;
                instr_mem_d[tail_q] = bus.imem_data;
                tail_d              = tail_q + PW'(1);
            end
            if (rd_en) begin
                head_d = head_q + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: fetched {pc, instr} pairs are queued when fetched and
// compared against the head output every cycle; scenario tasks add targeted checks.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   n_vec   = 0;
    int   n_err   = 0;

    entry_t      sb[$];
    logic [63:0] m_pc    = RESET_PC;
    int          m_count = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F13;
    endfunction

    assign bus.imem_data = instr_of(bus.imem_addr);

    // Reference queue: compare at each falling edge, then advance to the state after the next rising edge.
    always @(negedge clk) begin : monitor
        logic          byp, pop, fetch;
        logic [CW-1:0] exp_cnt;
        entry_t        e;
        if (!reset_n) begin
            sb.delete();
            m_pc    = RESET_PC;
            m_count = 0;
        end else begin
            byp     = BYP && (m_count == 0) && bus.fetch_enable && !bus.redirect_valid;
            exp_cnt = CW'(m_count);
            n_vec++;
            if (bus.imem_addr !== m_pc) begin
                n_err++;
                $display("FAIL sb_imem_addr t=%0t: got %h expected %h", $time, bus.imem_addr, m_pc);
            end
            n_vec++;
            if (bus.count !== exp_cnt) begin
                n_err++;
                $display("FAIL sb_count t=%0t: got %0d expected %0d", $time, bus.count, exp_cnt);
            end
            n_vec++;
            if (bus.out_valid !== ((m_count != 0) || byp)) begin
                n_err++;
                $display("FAIL sb_out_valid t=%0t: got %b expected %b", $time, bus.out_valid, (m_count != 0) || byp);
            end
            if (byp)               e = '{m_pc, instr_of(m_pc)};
            else if (m_count != 0) e = sb[0];
            else                   e = '0;
            n_vec++;
            if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                n_err++;
                $display("FAIL sb_head t=%0t: got pc=%h instr=%h expected pc=%h instr=%h",
                         $time, bus.out_pc, bus.out_instr, e.pc, e.instr);
            end
            if (bus.redirect_valid) begin
                sb.delete();
                m_pc = bus.redirect_pc;
            end else begin
                pop   = (m_count != 0) && bus.out_ready;
                fetch = bus.fetch_enable && ((m_count < DEPTH) || pop);
                if (pop) void'(sb.pop_front());
                if (fetch) begin
                    if (!(byp && bus.out_ready)) sb.push_back('{m_pc, instr_of(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
            end
            m_count = sb.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic fe, input logic rdy);
        tick();
        reset_n              = 1'b0;
        bus.fetch_enable     = fe;
        bus.out_ready        = rdy;
        bus.redirect_valid   = 1'b0;
        @(negedge clk);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.fetch_enable   = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #1 reset_n = 1'b0;
        #2;
        n_vec++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL reset_state: got count=%0d valid=%b addr=%h expected 0 0 %h",
                     bus.count, bus.out_valid, bus.imem_addr, RESET_PC);
        end
        n_vec++;
        if (bus.out_pc !== '0 || bus.out_instr !== '0) begin
            n_err++;
            $display("FAIL reset_out_zero: got pc=%h instr=%h expected 0 0", bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp;
        tick();
        bus.fetch_enable = 1'b1;
        bus.out_ready    = 1'b1;
        reset_n          = 1'b1;
        #1;
        n_vec++;
        if (bus.out_valid !== BYP) begin
            n_err++;
            $display("FAIL first_valid_latency: got %b expected %b", bus.out_valid, BYP);
        end
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = (BYP ? 64'd4 : 64'd0) + 64'(4 * i);
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp) begin
                n_err++;
                $display("FAIL stream_pc[%0d]: got valid=%b pc=%h expected 1 %h", i, bus.out_valid, bus.out_pc, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        restart(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.out_pc !== 64'h0) begin
                n_err++;
                $display("FAIL stall_pc_stable[%0d]: got %h expected 0", i, bus.out_pc);
            end
        end
        n_vec++;
        if (bus.count !== CW'(DEPTH) || bus.imem_addr !== 64'd16) begin
            n_err++;
            $display("FAIL stall_full: got count=%0d addr=%h expected %0d 10", bus.count, bus.imem_addr, DEPTH);
        end
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = 64'(4 * k);
            n_vec++;
            if (bus.out_pc !== exp || bus.count !== CW'(DEPTH) || bus.imem_addr !== 64'd16 + exp) begin
                n_err++;
                $display("FAIL full_flow[%0d]: got pc=%h count=%0d addr=%h expected %h %0d %h",
                         k, bus.out_pc, bus.count, bus.imem_addr, exp, DEPTH, 64'd16 + exp);
            end
        end
    endtask

    task automatic test_redirect();
        bit seen;
        restart(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.count !== CW'(3)) begin
            n_err++;
            $display("FAIL redirect_pre_count: got %0d expected 3", bus.count);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        bus.out_ready      = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.count !== '0 || bus.imem_addr !== 64'h100) begin
            n_err++;
            $display("FAIL redirect_flush: got count=%0d addr=%h expected 0 100", bus.count, bus.imem_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                n_vec++;
                if (bus.out_pc !== 64'h100) begin
                    n_err++;
                    $display("FAIL redirect_next_pc: got %h expected 100", bus.out_pc);
                end
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL redirect_timeout: got no out_valid expected one within 4 cycles");
        end
    endtask

    task automatic test_redirect_full();
        tick();
        bus.fetch_enable = 1'b1;
        bus.out_ready    = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (bus.count !== CW'(DEPTH)) begin
            n_err++;
            $display("FAIL redirect_full_pre: got %0d expected %0d", bus.count, DEPTH);
        end
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h200;
        tick();
        bus.redirect_valid = 1'b0;
        bus.fetch_enable   = 1'b0;
        n_vec++;
        if (bus.count !== '0 || bus.imem_addr !== 64'h200 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_full_flush: got count=%0d addr=%h valid=%b expected 0 200 0",
                     bus.count, bus.imem_addr, bus.out_valid);
        end
    endtask

    task automatic test_fetch_hold();
        tick();
        bus.fetch_enable = 1'b1;
        bus.out_ready    = 1'b0;
        tick();
        tick();
        bus.fetch_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (bus.imem_addr !== 64'h208 || bus.count !== CW'(2) || bus.out_pc !== 64'h200) begin
                n_err++;
                $display("FAIL hold[%0d]: got addr=%h count=%0d pc=%h expected 208 2 200",
                         i, bus.imem_addr, bus.count, bus.out_pc);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.out_instr !== '0) begin
            n_err++;
            $display("FAIL hold_drain: got count=%0d valid=%b pc=%h instr=%h expected 0 0 0 0",
                     bus.count, bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] exp;
        tick();
        bus.fetch_enable = 1'b1;
        bus.out_ready    = 1'b1;
        repeat (3) tick();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL async_reset: got count=%0d valid=%b addr=%h expected 0 0 %h",
                     bus.count, bus.out_valid, bus.imem_addr, RESET_PC);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = (BYP ? 64'd4 : 64'd0) + 64'(4 * i);
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp) begin
                n_err++;
                $display("FAIL post_reset_pc[%0d]: got valid=%b pc=%h expected 1 %h", i, bus.out_valid, bus.out_pc, exp);
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [63:0] got[$];
        tick();
        bus.fetch_enable   = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        bus.fetch_enable   = 1'b1;
        @(negedge clk);
        if (bus.out_valid === 1'b1) got.push_back(bus.out_pc);
        tick();
        @(negedge clk);
        if (bus.out_valid === 1'b1) got.push_back(bus.out_pc);
        tick();
        bus.fetch_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) got.push_back(bus.out_pc);
        end
        n_vec++;
        if (got.size() != 2) begin
            n_err++;
            $display("FAIL wrap_count: got %0d outputs expected 2", got.size());
        end else begin
            n_vec++;
            if (got[0] !== 64'hFFFF_FFFF_FFFF_FFFC || got[1] !== 64'h0) begin
                n_err++;
                $display("FAIL wrap_pc: got %h,%h expected fffffffffffffffc,0", got[0], got[1]);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_full();
        test_fetch_hold();
        test_async_reset();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 64'h0: fetch PC after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_enable  input  1  permits a fetch this cycle.
REQ-006 imem_addr  output  64  fetch PC presented to instruction memory.
REQ-007 imem_data  input  32  instruction at imem_addr, valid in the same cycle (combinational memory).
REQ-008 redirect_valid  input  1  taken branch resolved in MEM; flush and redirect.
REQ-009 redirect_pc  input  64  branch target.
REQ-010 out_valid  output  1  head entry is available to the IF/ID register.
REQ-011 out_pc  output  64  PC of the head entry.
REQ-012 out_instr  output  32  instruction of the head entry.
REQ-013 out_ready  input  1  IF/ID accepts the head entry; low means stall.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 imem_addr SHALL equal the internal fetch PC register at all times.
REQ-016 Push condition: fetch_enable & ~redirect_valid & (count<DEPTH | pop); a push writes {fetch PC, imem_data} at the tail, and fetch PC advances by 4 (modulo 2^64).
REQ-017 Pop condition: out_valid & out_ready & ~redirect_valid; a pop advances the head.
REQ-018 Simultaneous push and pop when full SHALL be allowed, leaving count unchanged.
REQ-019 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 Without bypass, out_valid SHALL be (count!=0), and out_pc/out_instr SHALL come from the head entry; fetch-to-out latency is 1 cycle.
REQ-021 redirect_valid SHALL take priority over push and pop: next cycle count=0, fetch PC=redirect_pc, and no entry from the redirect cycle is retained.
REQ-022 While out_valid & ~out_ready, out_pc/out_instr SHALL remain stable.
REQ-023 When fetch_enable=0, fetch PC and queue contents SHALL hold, and pops SHALL continue.
REQ-024 count SHALL equal pushes minus pops since the last reset or redirect and SHALL never exceed DEPTH.

Reset
REQ-025 When reset_n=0: fetch PC=RESET_PC, count=0, out_valid=0, pointers=0, asynchronously.
REQ-026 Reset mid-operation SHALL discard all entries; the first fetch after release uses RESET_PC.
REQ-027 out_pc/out_instr SHALL read 0 while count=0 and bypass is inactive.

Configuration
REQ-028 Macro FETCH_QUEUE_BYPASS_EN, when defined: if count=0, fetch_enable=1 and redirect_valid=0, then out_valid=1, out_pc=fetch PC and out_instr=imem_data in the same cycle (0-cycle latency). If out_ready=1, the instruction SHALL NOT also be written to the queue; if out_ready=0, it SHALL be pushed normally.
REQ-029 Without FETCH_QUEUE_BYPASS_EN, REQ-020 applies unconditionally, and the macro's signals and logic SHALL be absent.

Verification
REQ-030 Release reset with fetch_enable=1 and out_ready=1 -> out_pc sequence 0,4,8,..., one per cycle; the first out_valid appears 1 cycle after the first fetch (0 cycles with the bypass macro).
REQ-031 Hold out_ready=0 with DEPTH=4 -> count reaches 4, imem_addr stays at 16, and out_pc stays 0; then raise out_ready -> pops resume and the queue stays full while fetching.
REQ-032 Queue holds 3 entries, assert redirect_valid with redirect_pc=64'h100 -> next cycle count=0 and imem_addr=64'h100; the next out_pc is 64'h100.
REQ-033 Assert redirect_valid in the same cycle as a full push and pop -> no push or pop occurs, and count=0 next cycle.
REQ-034 Pulse reset_n low mid-stream, between clock edges -> count=0, out_valid=0 and imem_addr=RESET_PC immediately.
REQ-035 Redirect to 64'hFFFF_FFFF_FFFF_FFFC and fetch 2 instructions -> out_pc sequence is FFFF_FFFF_FFFF_FFFC, then 0.
